// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the burst writer
//
// Purpose : default geometry of the burst-written memory and the FSM state
//           codes, shared by the top level and anything that decodes state.
// Ports   : none (package).

package mem_pkg;

  // Default geometry: DEPTH must equal 2**NUMBER so the write pointer wraps
  // for free when it overflows.
  localparam int MEM_WIDTH  = 8;
  localparam int MEM_NUMBER = 3;
  localparam int MEM_DEPTH  = 8;

  // FSM state codes, kept as plain constants so older tools and netlists
  // that probe the raw state bits keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - single write port RAM with registered read port
//
// Purpose : storage for the burst writer. Writes land at the rising edge
//           when we=1. Reads are registered: read=1 at an edge loads
//           data_out with the word stored before that edge, so a same-edge
//           read and write of one address returns the old word.
// Ports   : clk      - clock
//           rst      - synchronous active-high reset, clears data_out only
//           we       - write enable
//           waddr    - write address
//           wdata    - write data
//           read     - read enable, data_out holds when low
//           addr     - read address
//           data_out - registered read data

module sync_ram
  import mem_pkg::*;
#(
  parameter int WIDTH  = MEM_WIDTH,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int NUMBER = MEM_NUMBER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NUMBER-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              read,
  input  logic [NUMBER-1:0] addr,
  output logic [WIDTH-1:0]  data_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array has no reset so contents survive rst and the storage can map
  // onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem sees the pre-edge contents, which gives
  // read-old-data behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_burst_writer.sv
// rtl/mem_burst_writer.sv - burst write controller in front of sync_ram
//
// Purpose : accepts a burst request (start address and word count), then
//           writes one word per valid/ready handshake at consecutive
//           addresses, wrapping modulo DEPTH, and signals completion with a
//           one-cycle done pulse. Illegal lengths are rejected with done and
//           err together and no writes. A registered readback port reads the
//           storage independently of the burst engine.
// Ports   : clk        - clock, all state changes on its rising edge
//           rst        - synchronous active-high reset, highest priority
//           start      - burst request, sampled only in IDLE
//           start_addr - first write address
//           length     - word count, legal 1..DEPTH
//           in_valid   - in_data holds a valid word
//           in_ready   - block accepts a word this cycle (high in WRITE)
//           in_data    - write data word
//           busy       - state is not IDLE
//           done       - one-cycle pulse at burst end
//           err        - one-cycle pulse with done for a rejected burst
//           read       - readback enable
//           addr       - readback address
//           data_out   - registered readback data

module mem_burst_writer
  import mem_pkg::*;
#(
  parameter int WIDTH  = MEM_WIDTH,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int NUMBER = MEM_NUMBER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUMBER-1:0] start_addr,
  input  logic [NUMBER:0]   length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              read,
  input  logic [NUMBER-1:0] addr,
  output logic [WIDTH-1:0]  data_out
);

  localparam logic [NUMBER:0] MAX_LEN = (NUMBER+1)'(DEPTH);

  logic [1:0]        state;
  logic [NUMBER-1:0] ptr;
  logic [NUMBER:0]   remaining;
  logic              rejected;
  logic              len_ok;
  logic              beat;

  assign len_ok   = (length != '0) && (length <= MAX_LEN);
  assign in_ready = (state == ST_WRITE);
  assign beat     = in_ready && in_valid;
  assign busy     = (state != ST_IDLE);
  // done/err decode from state so reset clears them with no extra flops.
  assign done     = (state == ST_DONE);
  assign err      = done && rejected;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
      rejected  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr       <= start_addr;
            remaining <= length;
            if (len_ok) begin
              state    <= ST_WRITE;
              rejected <= 1'b0;
            end else begin
              state    <= ST_DONE;
              rejected <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // No valid word means a stall: nothing in this branch changes.
          if (in_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (NUMBER+1)'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          rejected <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sync_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUMBER (NUMBER)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (beat),
    .waddr    (ptr),
    .wdata    (in_data),
    .read     (read),
    .addr     (addr),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_mem_burst_writer.sv
// tb/tb_mem_burst_writer.sv - scoreboard bench for mem_burst_writer

module tb_mem_burst_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] length;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       read;
  logic [2:0] addr;
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [8];
  logic [7:0] rd_q [$];
  logic [7:0] last_rd;

  mem_burst_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .read       (read),
    .addr       (addr),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a);
    logic [7:0] exp;
    read = 1'b1;
    addr = a;
    rd_q.push_back(model_mem[a]);
    tick();
    read = 1'b0;
    exp = rd_q.pop_front();
    check($sformatf("read[%0d]", a), data_out, exp);
    last_rd = exp;
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) do_read(3'(i));
    addr = 3'd0;
    tick();
    check("read_hold", data_out, last_rd);
  endtask

  // vpat bit c gives in_valid on loop cycle c; beyond bit 15 valid is high.
  // noisy holds an illegal start request during the burst, which must be ignored.
  task automatic burst(input logic [2:0] sa, input logic [3:0] len,
                       input logic [7:0] base, input logic [15:0] vpat,
                       input bit noisy);
    logic [2:0] p;
    int beats;
    int cyc;
    start = 1'b1; start_addr = sa; length = len;
    tick();
    start = 1'b0;
    if (noisy) begin start = 1'b1; start_addr = 3'd5; length = 4'd0; end
    check("burst_busy", busy, 1'b1);
    p = sa;
    beats = 0;
    cyc = 0;
    while (beats < int'(len) && cyc < 64) begin
      in_valid = (cyc < 16) ? vpat[cyc] : 1'b1;
      in_data  = base + 8'(beats);
      check("in_ready_write", in_ready, 1'b1);
      check("no_early_done", done, 1'b0);
      if (in_valid) model_mem[p] = in_data;
      tick();
      if (in_valid) begin beats++; p = p + 3'd1; end
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("burst_done", done, 1'b1);
    check("burst_err", err, 1'b0);
    check("done_in_ready", in_ready, 1'b0);
    tick();
    check("done_pulse_end", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic reject(input logic [3:0] len);
    start = 1'b1; start_addr = 3'd2; length = len; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check($sformatf("rej%0d_done", len), done, 1'b1);
    check($sformatf("rej%0d_err", len), err, 1'b1);
    check($sformatf("rej%0d_ready", len), in_ready, 1'b0);
    tick();
    check($sformatf("rej%0d_clear", len), {busy, done, err}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0;
    in_valid = 1'b0; in_data = '0; read = 1'b0; addr = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_data_out", data_out, 8'h00);

    // Full-depth burst, valid held high.
    burst(3'd0, 4'd8, 8'h10, 16'hFFFF, 1'b0);
    read_all();

    // Wrapping burst.
    burst(3'd6, 4'd4, 8'hA0, 16'hFFFF, 1'b0);
    read_all();

    // Rejected lengths, no memory change.
    reject(4'd0);
    reject(4'd9);
    read_all();

    // Stalled valid pattern 1,0,0,1,1 with a start request held meanwhile.
    burst(3'd3, 4'd3, 8'h30, 16'h0019, 1'b1);
    read_all();

    // Reset after 2 of 5 beats.
    start = 1'b1; start_addr = 3'd2; length = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'h50 + 8'(i);
      model_mem[3'(2 + i)] = in_data;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_data_out", data_out, 8'h00);
    tick();
    check("abort_no_done", done, 1'b0);
    read_all();
    burst(3'd4, 4'd2, 8'hC0, 16'hFFFF, 1'b0);
    read_all();

    // Same-edge read and write of address 3.
    start = 1'b1; start_addr = 3'd3; length = 4'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF;
    read = 1'b1; addr = 3'd3;
    rd_q.push_back(model_mem[3]);
    tick();
    in_valid = 1'b0;
    model_mem[3] = 8'hFF;
    check("collide_old", data_out, rd_q.pop_front());
    check("collide_done", done, 1'b1);
    rd_q.push_back(model_mem[3]);
    tick();
    read = 1'b0;
    check("collide_new", data_out, rd_q.pop_front());
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
